cve2_fpu_issue_ctrl: RTL and testbench
======================================

Name: cve2_fpu_issue_ctrl

Overview:
Sequences single-outstanding FP operations from the ID stage into the EX-stage FPU (fpnew_top). It drives the FPU's in_valid/in_ready handshake and stalls ID until the result returns. It routes the result writeback to the FP or integer register file, emits fflags updates, and manages flush when an op is killed.

Parameters:
TimeoutCycles, 64, max cycles in WAIT before watchdog abort (used only with the optional feature; must be ≥2).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
id_req_i  in  1  ID holds a valid FP instruction ready to issue
id_rd_addr_i  in  5  destination register of the requesting instruction
id_rd_is_fp_i  in  1  1: FP regfile destination; 0: integer regfile destination
id_kill_i  in  1  kill current/in-flight FP op (exception, branch flush)
id_stall_o  out  1  hold ID stage
fpu_in_valid_o  out  1  to FPU in_valid
fpu_in_ready_i  in  1  from FPU in_ready
fpu_out_valid_i  in  1  from FPU out_valid (FPU out_ready is tied 1)
fpu_busy_i  in  1  from FPU busy
fpu_status_i  in  5  FPU status {NV,DZ,OF,UF,NX}
fpu_flush_o  out  1  to FPU flush
wb_we_o  out  1  result writeback strobe
wb_fp_o  out  1  writeback targets FP regfile
wb_addr_o  out  5  writeback register address
fflags_we_o  out  1  OR fflags_o into CSR fflags
fflags_o  out  5  exception flags of the completing op
err_o  out  1  watchdog abort pulse

Behaviour:
- Interface is fixed: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE, tag regs (addr, is_fp)=0, watchdog counter=0. All outputs are 0 during reset and in the cycle after reset.
- States: IDLE, ISSUE, WAIT, FLUSH.
- IDLE: fpu_in_valid_o = id_req_i & ~id_kill_i (combinational).
  - Handshake (in_ready=1) with out_valid=1 in the same cycle: complete immediately, stay IDLE.
  - Handshake without out_valid: latch tag, go to WAIT.
  - No handshake: latch tag, go to ISSUE.
- ISSUE: fpu_in_valid_o=1 held until in_ready.
  - Handshake with out_valid: complete, go to IDLE.
  - Handshake without out_valid: go to WAIT.
  - id_kill_i: drop valid (no handshake that cycle), go to IDLE, no flush needed.
- WAIT: fpu_in_valid_o=0.
  - out_valid: complete, go to IDLE.
  - id_kill_i: fpu_flush_o=1 for one cycle, go to FLUSH. Kill beats out_valid in the same cycle: no writeback, no fflags.
- FLUSH: id_stall_o=1, fpu_in_valid_o=0. Go to IDLE on the first cycle fpu_busy_i=0. Any stray out_valid is ignored.
- Complete (combinational, same cycle as out_valid):
  - wb_we_o=1, wb_addr_o/wb_fp_o from the tag (or from id_* ports when completing in IDLE).
  - fflags_we_o=1, fflags_o=fpu_status_i.
  - id_stall_o=0.
- id_stall_o=1 when:
  - state ∈ {ISSUE, WAIT, FLUSH} and not completing; or
  - IDLE with id_req_i and not completing.
- id_kill_i in IDLE with id_req_i: no valid, no stall.
- Minimum latency: 0 extra cycles (combinational FPU). Otherwise the ID stall lasts issue wait + FPU pipeline depth.
- Back-to-back: the op after a completion may issue in the next cycle; there is no dead cycle requirement.
- id_rd_* are sampled only at the handshake or the IDLE→ISSUE transition. Changes afterwards are ignored.
- Reset mid-op: returns to IDLE. No flush is issued (the FPU is reset by its own reset).

Optional Feature:
CVE2_FPU_WATCHDOG_EN:
- Defined:
  - An 8-bit-min counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TimeoutCycles-1 with no out_valid: fpu_flush_o=1 and err_o=1 for one cycle, no writeback, go to FLUSH.
  - out_valid in the same cycle as timeout wins (normal completion).
- Undefined: no counter, err_o tied 0.

Test Plan:
- Req rd=5, is_fp=1; in_ready=1 at cycle 0; out_valid at cycle 3 with status=5'b00001 → wb_we_o=1, wb_addr_o=5, wb_fp_o=1, fflags_o=00001 at cycle 3; id_stall_o=1 in cycles 0–2 and 0 in cycle 3.
- in_ready=0 for 2 cycles, then 1 → fpu_in_valid_o high for exactly 3 cycles; id_rd changed to 9 in cycle 1 → wb_addr_o still 5.
- Same-cycle handshake and out_valid (combinational FPU), rd=3, is_fp=0 → wb_we_o=1, wb_fp_o=0, id_stall_o=0 in that cycle; next req issues in the following cycle.
- id_kill_i in WAIT coincident with out_valid → fpu_flush_o=1, wb_we_o=0, fflags_we_o=0; with fpu_busy_i=1 for 2 more cycles, id_stall_o stays high until busy drops, then IDLE.
- Reset asserted in WAIT → next cycle state IDLE, all outputs 0; a following req issues normally.
- With CVE2_FPU_WATCHDOG_EN, TimeoutCycles=8, no out_valid → err_o and fpu_flush_o pulse at the 8th WAIT cycle, wb_we_o=0; without the macro, err_o stays 0 forever.

Source files
------------

// File: rtl/cve2_fpu_issue_ctrl.sv
// cve2_fpu_issue_ctrl: single-outstanding FP op sequencer between ID and fpnew_top.
// Optional watchdog abort of a stuck op is enabled by defining CVE2_FPU_WATCHDOG_EN.
module cve2_fpu_issue_ctrl #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_req_i,
    input  logic [4:0] id_rd_addr_i,
    input  logic       id_rd_is_fp_i,
    input  logic       id_kill_i,
    output logic       id_stall_o,
    output logic       fpu_in_valid_o,
    input  logic       fpu_in_ready_i,
    input  logic       fpu_out_valid_i,
    input  logic       fpu_busy_i,
    input  logic [4:0] fpu_status_i,
    output logic       fpu_flush_o,
    output logic       wb_we_o,
    output logic       wb_fp_o,
    output logic [4:0] wb_addr_o,
    output logic       fflags_we_o,
    output logic [4:0] fflags_o,
    output logic       err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_e;
    state_e     state_q, state_d;
    logic [4:0] addr_q, addr_d;
    logic       fp_q, fp_d;
    logic       rst_q, blk;
    logic       in_valid, flush, err, stall, complete, use_id, timeout;
    // Outputs stay quiet both during reset and in the first cycle after it.
    assign blk = rst_i | rst_q;
`ifdef CVE2_FPU_WATCHDOG_EN
    localparam int unsigned CW = (TimeoutCycles > 256) ? $clog2(TimeoutCycles) : 8;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != WAIT) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end
    assign timeout = (state_q == WAIT) && (cnt_q == CW'(TimeoutCycles - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TimeoutCycles;
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        fp_d     = fp_q;
        in_valid = 1'b0;
        flush    = 1'b0;
        err      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        use_id   = 1'b0;
        case (state_q)
            IDLE: begin
                in_valid = id_req_i & ~id_kill_i & ~blk;
                if (in_valid) begin
                    if (fpu_in_ready_i && fpu_out_valid_i) begin
                        complete = 1'b1;
                        use_id   = 1'b1;
                    end else begin
                        addr_d  = id_rd_addr_i;
                        fp_d    = id_rd_is_fp_i;
                        state_d = fpu_in_ready_i ? WAIT : ISSUE;
                    end
                end
                stall = in_valid & ~complete;
            end
            ISSUE: begin
                if (id_kill_i) begin
                    state_d = IDLE;
                end else begin
                    in_valid = 1'b1;
                    if (fpu_in_ready_i) begin
                        complete = fpu_out_valid_i;
                        state_d  = fpu_out_valid_i ? IDLE : WAIT;
                    end
                end
                stall = ~complete;
            end
            WAIT: begin
                // A kill wins over a same-cycle result; a result wins over the watchdog.
                if (id_kill_i) begin
                    flush   = 1'b1;
                    state_d = FLUSH;
                end else if (fpu_out_valid_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timeout) begin
                    flush   = 1'b1;
                    err     = 1'b1;
                    state_d = FLUSH;
                end
                stall = ~complete;
            end
            default: begin
                stall   = 1'b1;
                state_d = fpu_busy_i ? FLUSH : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fp_q    <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fp_q    <= fp_d;
            rst_q   <= 1'b0;
        end
    end
    assign id_stall_o     = stall & ~blk;
    assign fpu_in_valid_o = in_valid & ~blk;
    assign fpu_flush_o    = flush & ~blk;
    assign err_o          = err & ~blk;
    assign wb_we_o        = complete & ~blk;
    assign wb_fp_o        = wb_we_o & (use_id ? id_rd_is_fp_i : fp_q);
    assign wb_addr_o      = wb_we_o ? (use_id ? id_rd_addr_i : addr_q) : 5'd0;
    assign fflags_we_o    = wb_we_o;
    assign fflags_o       = wb_we_o ? fpu_status_i : 5'd0;
endmodule

// File: tb/tb_cve2_fpu_issue_ctrl.sv
// tb_cve2_fpu_issue_ctrl: directed vector table, hand sequences and a random run against a reference model.
module tb_cve2_fpu_issue_ctrl;
    localparam int TO = 8;
`ifdef CVE2_FPU_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    typedef struct packed {
        logic       rst;
        logic       req;
        logic [4:0] addr;
        logic       fp;
        logic       kill;
        logic       rdy;
        logic       ov;
        logic       busy;
        logic [4:0] st;
    } in_t;
    typedef struct packed {
        in_t         i;
        logic [16:0] e;
    } row_t;

    logic clk = 1'b0;
    logic rst, req, fp, kill, rdy, ov, busy;
    logic [4:0] addr, st;
    logic stall, vld, flush, we, wfp, fwe, err;
    logic [4:0] waddr, ff;
    logic [16:0] out_vec;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cve2_fpu_issue_ctrl #(.TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst), .id_req_i(req), .id_rd_addr_i(addr), .id_rd_is_fp_i(fp),
        .id_kill_i(kill), .id_stall_o(stall), .fpu_in_valid_o(vld), .fpu_in_ready_i(rdy),
        .fpu_out_valid_i(ov), .fpu_busy_i(busy), .fpu_status_i(st), .fpu_flush_o(flush),
        .wb_we_o(we), .wb_fp_o(wfp), .wb_addr_o(waddr), .fflags_we_o(fwe), .fflags_o(ff),
        .err_o(err)
    );
    assign out_vec = {stall, vld, flush, we, wfp, waddr, fwe, ff, err};

    function automatic in_t mk_in(logic r, logic q, logic [4:0] a, logic f, logic k,
                                  logic y, logic o, logic b, logic [4:0] s);
        return '{rst: r, req: q, addr: a, fp: f, kill: k, rdy: y, ov: o, busy: b, st: s};
    endfunction
    function automatic logic [16:0] mk_out(logic s, logic v, logic fl, logic w, logic wf,
                                           logic [4:0] wa, logic fw, logic [4:0] f, logic e);
        return {s, v, fl, w, wf, wa, fw, f, e};
    endfunction

    task automatic drive(input in_t x);
        @(posedge clk);
        #1;
        rst = x.rst; req = x.req; addr = x.addr; fp = x.fp; kill = x.kill;
        rdy = x.rdy; ov = x.ov; busy = x.busy; st = x.st;
    endtask
    task automatic check(input logic [16:0] e, input string name);
        @(negedge clk);
        checks++;
        if (out_vec !== e) begin
            errors++;
            $display("FAIL %s: got stall,vld,flush,we,wfp,addr,fwe,flags,err=%b required=%b", name, out_vec, e);
        end
    endtask

    // Reference model: tracks whether an op is held, accepted, or being drained.
    bit m_blk, m_op, m_acc, m_drain, m_fp;
    logic [4:0] m_addr;
    int m_wcnt;
    task automatic model(input in_t x, output logic [16:0] e);
        logic s, v, fl, w, wf, er;
        logic [4:0] wa;
        s = 0; v = 0; fl = 0; w = 0; wf = 0; er = 0; wa = 0;
        if (x.rst || m_blk) begin
            m_op = 0; m_acc = 0; m_drain = 0; m_addr = 0; m_fp = 0; m_wcnt = 0;
            m_blk = x.rst;
        end else if (m_drain) begin
            s = 1;
            if (!x.busy) m_drain = 0;
        end else if (m_op && !m_acc) begin
            s = 1;
            if (x.kill) m_op = 0;
            else begin
                v = 1;
                if (x.rdy && x.ov) begin
                    s = 0; w = 1; wa = m_addr; wf = m_fp; m_op = 0;
                end else if (x.rdy) begin
                    m_acc = 1; m_wcnt = 0;
                end
            end
        end else if (m_op) begin
            s = 1;
            if (x.kill) begin
                fl = 1; m_drain = 1; m_op = 0; m_acc = 0;
            end else if (x.ov) begin
                s = 0; w = 1; wa = m_addr; wf = m_fp; m_op = 0; m_acc = 0;
            end else if (WD && m_wcnt == TO - 1) begin
                fl = 1; er = 1; m_drain = 1; m_op = 0; m_acc = 0;
            end else m_wcnt++;
        end else if (x.req && !x.kill) begin
            v = 1;
            if (x.rdy && x.ov) begin
                w = 1; wa = x.addr; wf = x.fp;
            end else begin
                s = 1; m_op = 1; m_acc = x.rdy; m_addr = x.addr; m_fp = x.fp; m_wcnt = 0;
            end
        end
        e = {s, v, fl, w, wf, wa, w, w ? x.st : 5'd0, er};
    endtask

    row_t rows[20];
    bit fired;
    logic [16:0] exp_v;
    in_t r_in;

    initial begin
        rst = 1; req = 0; addr = 0; fp = 0; kill = 0; rdy = 0; ov = 0; busy = 0; st = 0;
        rows[0]  = '{mk_in(1,0,0,0,0,0,0,0,0),      mk_out(0,0,0,0,0,0,0,0,0)};
        rows[1]  = '{mk_in(0,1,5,1,0,1,0,0,0),      mk_out(0,0,0,0,0,0,0,0,0)};
        rows[2]  = '{mk_in(0,1,5,1,0,1,0,0,0),      mk_out(1,1,0,0,0,0,0,0,0)};
        rows[3]  = '{mk_in(0,1,7,0,0,0,0,1,0),      mk_out(1,0,0,0,0,0,0,0,0)};
        rows[4]  = '{mk_in(0,1,7,0,0,0,0,1,0),      mk_out(1,0,0,0,0,0,0,0,0)};
        rows[5]  = '{mk_in(0,1,7,0,0,0,1,1,5'd1),   mk_out(0,0,0,1,1,5,1,5'd1,0)};
        rows[6]  = '{mk_in(0,1,5,0,0,0,0,0,0),      mk_out(1,1,0,0,0,0,0,0,0)};
        rows[7]  = '{mk_in(0,1,9,1,0,0,0,0,0),      mk_out(1,1,0,0,0,0,0,0,0)};
        rows[8]  = '{mk_in(0,1,9,1,0,1,0,0,0),      mk_out(1,1,0,0,0,0,0,0,0)};
        rows[9]  = '{mk_in(0,0,9,1,0,0,1,0,5'd16),  mk_out(0,0,0,1,0,5,1,5'd16,0)};
        rows[10] = '{mk_in(0,1,3,0,0,1,1,0,5'd4),   mk_out(0,1,0,1,0,3,1,5'd4,0)};
        rows[11] = '{mk_in(0,1,4,1,0,1,0,1,0),      mk_out(1,1,0,0,0,0,0,0,0)};
        rows[12] = '{mk_in(0,0,0,0,1,0,1,1,5'd31),  mk_out(1,0,1,0,0,0,0,0,0)};
        rows[13] = '{mk_in(0,0,0,0,0,0,0,1,0),      mk_out(1,0,0,0,0,0,0,0,0)};
        rows[14] = '{mk_in(0,0,0,0,0,0,1,1,5'd2),   mk_out(1,0,0,0,0,0,0,0,0)};
        rows[15] = '{mk_in(0,0,0,0,0,0,0,0,0),      mk_out(1,0,0,0,0,0,0,0,0)};
        rows[16] = '{mk_in(0,1,8,1,1,1,1,0,5'd3),   mk_out(0,0,0,0,0,0,0,0,0)};
        rows[17] = '{mk_in(0,1,2,0,0,0,0,0,0),      mk_out(1,1,0,0,0,0,0,0,0)};
        rows[18] = '{mk_in(0,1,2,0,1,1,1,0,5'd1),   mk_out(1,0,0,0,0,0,0,0,0)};
        rows[19] = '{mk_in(0,0,0,0,0,0,0,0,0),      mk_out(0,0,0,0,0,0,0,0,0)};
        for (int i = 0; i < 20; i++) begin
            drive(rows[i].i);
            check(rows[i].e, $sformatf("vec%0d", i));
        end

        drive(mk_in(0,1,10,1,0,1,0,0,0));
        check(mk_out(1,1,0,0,0,0,0,0,0), "enter_wait");
        drive(mk_in(1,0,0,0,0,0,1,1,5'd3));
        check(mk_out(0,0,0,0,0,0,0,0,0), "rst_in_wait");
        drive(mk_in(0,1,6,0,0,1,1,0,5'd2));
        check(mk_out(0,0,0,0,0,0,0,0,0), "after_rst");
        drive(mk_in(0,1,6,0,0,1,1,0,5'd2));
        check(mk_out(0,1,0,1,0,6,1,5'd2,0), "post_rst_issue");

        drive(mk_in(0,1,11,1,0,1,0,1,0));
        check(mk_out(1,1,0,0,0,0,0,0,0), "wd_enter");
        fired = 0;
        for (int k = 0; k < 12 && !fired; k++) begin
            drive(mk_in(0,0,0,0,0,0,0,1,0));
            fired = WD && k == TO - 1;
            check(mk_out(1,0,fired,0,0,0,0,0,fired), $sformatf("wd_cyc%0d", k));
        end
        drive(mk_in(0,0,0,0,1,0,0,1,0));
        check(mk_out(1,0,!fired,0,0,0,0,0,0), "wd_kill");
        drive(mk_in(0,0,0,0,0,0,0,0,0));
        check(mk_out(1,0,0,0,0,0,0,0,0), "wd_drain");

        for (int c = 0; c < 3000; c++) begin
            r_in.rst  = (c == 0) || ($urandom_range(99) < 2);
            r_in.req  = $urandom_range(99) < 70;
            r_in.addr = 5'($urandom);
            r_in.fp   = 1'($urandom);
            r_in.kill = $urandom_range(99) < 8;
            r_in.rdy  = $urandom_range(99) < 50;
            r_in.ov   = $urandom_range(99) < 25;
            r_in.busy = $urandom_range(99) < 50;
            r_in.st   = 5'($urandom);
            drive(r_in);
            model(r_in, exp_v);
            check(exp_v, $sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
